flow_table_lookup: RTL and testbench

- Consumer side of the TFE hashing stage. Takes a registered hash, reverse hash and the 104-bit IP tuple, and resolves the tuple against a direct-mapped flow table.
- Reports one of four outcomes: forward hit, reverse hit, new-flow insert, or bucket collision.
- Sits between the hashing stage and per-flow feature accumulation. Its result index addresses the per-flow state.

---
 rtl/flow_pkg.sv | 15 +
 rtl/flow_tuple_ram.sv | 17 +
 rtl/flow_table_lookup.sv | 108 ++++++++++
 tb/tb_flow_table_lookup.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/flow_pkg.sv
// flow_pkg: shared widths, tuple field layout and lookup FSM states for the flow table.
package flow_pkg;
  localparam int TUPLE_W = 104;
  localparam int IDX_W = 10;
  localparam int DROP_W = 16;
  localparam int DEPTH = 1 << IDX_W;
  localparam int SIP_LSB = 72;
  localparam int DIP_LSB = 40;
  localparam int SPORT_LSB = 24;
  localparam int DPORT_LSB = 8;
  typedef enum logic [2:0] {IDLE, RD_F, CMP_F, RD_R, CMP_R, INS} state_e;
  function automatic logic [TUPLE_W-1:0] reverse_tuple(input logic [TUPLE_W-1:0] t);
    return {t[DIP_LSB+:32], t[SIP_LSB+:32], t[DPORT_LSB+:16], t[SPORT_LSB+:16], t[7:0]};
  endfunction
endpackage

// File: rtl/flow_tuple_ram.sv
// flow_tuple_ram: simple dual-port tuple store, one write port and one registered read port.
module flow_tuple_ram
  import flow_pkg::*;
(
  input  logic               clk,
  input  logic               we_i,
  input  logic [IDX_W-1:0]   waddr_i,
  input  logic [TUPLE_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]   raddr_i,
  output logic [TUPLE_W-1:0] rdata_o
);
  logic [TUPLE_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/flow_table_lookup.sv
// flow_table_lookup: resolves an IP tuple against a direct-mapped flow table (fwd hit, rev hit, insert, collision).
module flow_table_lookup
  import flow_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        hash,
  input  logic [31:0]        r_hash,
  input  logic [TUPLE_W-1:0] ip_tuple,
  input  logic               hash_v,
  output logic               in_ready,
  input  logic               clr_v,
  input  logic [IDX_W-1:0]   clr_idx,
  output logic               res_v,
  output logic               res_hit,
  output logic               res_dir,
  output logic               res_new,
  output logic               res_full,
  output logic [IDX_W-1:0]   res_idx,
  output logic [DROP_W-1:0]  drop_cnt
);
  state_e             state_q;
  logic [DEPTH-1:0]   valid_q;
  logic [TUPLE_W-1:0] tuple_q, rdata;
  logic [IDX_W-1:0]   idx_f_q, idx_r_q, clr_idx_q;
  logic               clr_pend_q;
  logic [DROP_W-1:0]  drop_q;
  logic               ram_we;
  logic               unused_hash_bits;
  assign unused_hash_bits = ^{hash[31:IDX_W], r_hash[31:IDX_W]};
  // A clear request (new or pending) takes the IDLE cycle away from lookups.
  assign in_ready = rst_n && state_q == IDLE && !clr_pend_q && !clr_v;
  assign ram_we = state_q == INS && !valid_q[idx_f_q];
  assign drop_cnt = drop_q;
  flow_tuple_ram u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (idx_f_q),
    .wdata_i (tuple_q),
    .raddr_i (state_q == RD_F ? idx_f_q : idx_r_q),
    .rdata_o (rdata)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      tuple_q    <= '0;
      idx_f_q    <= '0;
      idx_r_q    <= '0;
      clr_idx_q  <= '0;
      clr_pend_q <= 1'b0;
      drop_q     <= '0;
      res_v      <= 1'b0;
      res_hit    <= 1'b0;
      res_dir    <= 1'b0;
      res_new    <= 1'b0;
      res_full   <= 1'b0;
      res_idx    <= '0;
    end else begin
      res_v    <= 1'b0;
      res_hit  <= 1'b0;
      res_new  <= 1'b0;
      res_full <= 1'b0;
      if (hash_v && !in_ready && drop_q != '1) drop_q <= drop_q + 1'b1;
      if (state_q == IDLE && (clr_v || clr_pend_q)) begin
        valid_q[clr_v ? clr_idx : clr_idx_q] <= 1'b0;
        clr_pend_q <= 1'b0;
      end else if (clr_v) begin
        clr_pend_q <= 1'b1;
        clr_idx_q  <= clr_idx;
      end
      case (state_q)
        IDLE: if (hash_v && in_ready) begin
          tuple_q <= ip_tuple;
          idx_f_q <= hash[IDX_W-1:0];
          idx_r_q <= r_hash[IDX_W-1:0];
          state_q <= RD_F;
        end
        RD_F: state_q <= CMP_F;
        CMP_F: if (valid_q[idx_f_q] && rdata == tuple_q) begin
          res_v   <= 1'b1;
          res_hit <= 1'b1;
          res_dir <= 1'b0;
          res_idx <= idx_f_q;
          state_q <= IDLE;
        end else state_q <= RD_R;
        RD_R: state_q <= CMP_R;
        CMP_R: if (valid_q[idx_r_q] && rdata == reverse_tuple(tuple_q)) begin
          res_v   <= 1'b1;
          res_hit <= 1'b1;
          res_dir <= 1'b1;
          res_idx <= idx_r_q;
          state_q <= IDLE;
        end else state_q <= INS;
        INS: begin
          res_v    <= 1'b1;
          res_dir  <= 1'b0;
          res_idx  <= idx_f_q;
          res_new  <= !valid_q[idx_f_q];
          res_full <= valid_q[idx_f_q];
          if (!valid_q[idx_f_q]) valid_q[idx_f_q] <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flow_table_lookup.sv
// tb_flow_table_lookup: directed plan plus randomized lookups/clears checked against a table model.
module tb_flow_table_lookup;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  hash = '0, r_hash = '0;
  logic [103:0] ip_tuple = '0;
  logic         hash_v = 1'b0, clr_v = 1'b0;
  logic [9:0]   clr_idx = '0;
  logic         in_ready, res_v, res_hit, res_dir, res_new, res_full;
  logic [9:0]   res_idx;
  logic [15:0]  drop_cnt;
  int           n_chk = 0, n_err = 0, drops = 0;
  bit           mvalid [1024];
  logic [103:0] mtab [1024];
  logic [103:0] pool [8];

  always #5 clk = ~clk;

  flow_table_lookup dut (
    .clk(clk), .rst_n(rst_n), .hash(hash), .r_hash(r_hash), .ip_tuple(ip_tuple),
    .hash_v(hash_v), .in_ready(in_ready), .clr_v(clr_v), .clr_idx(clr_idx),
    .res_v(res_v), .res_hit(res_hit), .res_dir(res_dir), .res_new(res_new),
    .res_full(res_full), .res_idx(res_idx), .drop_cnt(drop_cnt)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [103:0] rand_tuple();
    logic [127:0] x = {$urandom, $urandom, $urandom, $urandom};
    return x[103:0];
  endfunction

  function automatic logic [103:0] rev(input logic [103:0] t);
    logic [31:0] sip, dip;
    logic [15:0] sp, dp;
    logic [7:0]  pr;
    {sip, dip, sp, dp, pr} = t;
    return {dip, sip, dp, sp, pr};
  endfunction

  task automatic wait_ready();
    int b = 0;
    while (!in_ready && b < 20) begin
      @(negedge clk);
      b++;
    end
    check("ready_wait", in_ready, 1);
  endtask

  // Predicts outcome/latency from the table rules, drives one lookup, checks the result.
  task automatic lookup(input logic [103:0] t, input logic [31:0] h, input logic [31:0] rh,
                        input int ndrop, input bit do_clr, input logic [9:0] cidx);
    logic [9:0] f = h[9:0], r = rh[9:0], e_idx;
    int lat, n;
    bit e_hit, e_dir, e_new, e_full;
    e_hit = 0; e_dir = 0; e_new = 0; e_full = 0;
    if (mvalid[f] && mtab[f] == t) begin
      lat = 2; e_hit = 1; e_idx = f;
    end else if (mvalid[r] && mtab[r] == rev(t)) begin
      lat = 4; e_hit = 1; e_dir = 1; e_idx = r;
    end else begin
      lat = 5; e_idx = f;
      if (mvalid[f]) e_full = 1;
      else e_new = 1;
    end
    if (ndrop > lat) ndrop = lat;
    wait_ready();
    ip_tuple = t; hash = h; r_hash = rh; hash_v = 1'b1;
    @(posedge clk);
    @(negedge clk);
    hash_v = ndrop > 0; ip_tuple = rand_tuple(); clr_v = do_clr; clr_idx = cidx;
    n = 0;
    while (n < 10) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      clr_v = 1'b0;
      if (res_v) break;
      hash_v = n < ndrop;
    end
    hash_v = 1'b0;
    drops += ndrop;
    check("latency", n, lat);
    check("res_v", res_v, 1);
    check("res_hit", res_hit, e_hit);
    check("res_dir", res_dir, e_dir);
    check("res_new", res_new, e_new);
    check("res_full", res_full, e_full);
    check("res_idx", res_idx, e_idx);
    check("ready_at_res", in_ready, !do_clr);
    check("drop_cnt", drop_cnt, drops);
    if (e_new) begin
      mvalid[f] = 1;
      mtab[f] = t;
    end
    if (do_clr) mvalid[cidx] = 0;
    @(negedge clk);
    check("res_v_pulse", res_v, 0);
  endtask

  task automatic clear_idle(input logic [9:0] idx, input bit with_hash);
    wait_ready();
    clr_v = 1'b1; clr_idx = idx; hash_v = with_hash; ip_tuple = rand_tuple();
    #1 check("ready_clr", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    clr_v = 1'b0; hash_v = 1'b0;
    mvalid[idx] = 0;
    if (with_hash) drops++;
    check("drop_clr", drop_cnt, drops);
  endtask

  initial begin
    logic [103:0] t, u, v, p, x;
    bit seen;
    t = 104'h0a000001_0a000002_1234_0050_06;
    u = 104'hc0a80101_c0a80102_abcd_01bb_11;
    v = 104'h01020304_05060708_1111_2222_06;
    p = 104'h0b0b0b0b_0b0b0b0b_0035_0035_11;
    for (int i = 0; i < 8; i++) pool[i] = rand_tuple();
    pool[7] = p;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_res_v", res_v, 0);
    check("rst_hit", res_hit, 0);
    check("rst_dir", res_dir, 0);
    check("rst_new", res_new, 0);
    check("rst_full", res_full, 0);
    check("rst_idx", res_idx, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_ready", in_ready, 1);
    lookup(t, 32'h5, 32'h9, 0, 0, 0);
    lookup(t, 32'h5, 32'h9, 0, 0, 0);
    lookup(rev(t), 32'h9, 32'h5, 0, 0, 0);
    lookup(u, 32'h405, 32'h11, 0, 0, 0);
    lookup(t, 32'h5, 32'h9, 0, 0, 0);
    lookup(u, 32'h405, 32'h11, 3, 0, 0);
    check("drop3", drop_cnt, 3);
    clear_idle(10'd5, 1);
    check("drop4", drop_cnt, 4);
    lookup(t, 32'h5, 32'h9, 0, 0, 0);
    lookup(t, 32'h5, 32'h9, 0, 1, 10'd5);
    lookup(t, 32'h5, 32'h9, 0, 0, 0);
    lookup(p, 32'h30, 32'h31, 0, 0, 0);
    lookup(p, 32'h30, 32'h30, 0, 0, 0);
    wait_ready();
    ip_tuple = v; hash = 32'h20; r_hash = 32'h21; hash_v = 1'b1;
    @(posedge clk);
    @(negedge clk);
    hash_v = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      seen |= res_v;
    end
    rst_n = 1'b1;
    #1 check("abort_no_res", seen, 0);
    check("abort_ready", in_ready, 1);
    check("abort_drop", drop_cnt, 0);
    drops = 0;
    for (int i = 0; i < 1024; i++) mvalid[i] = 0;
    @(negedge clk);
    lookup(t, 32'h5, 32'h9, 0, 0, 0);
    for (int k = 0; k < 300; k++) begin
      logic [31:0] h, rh;
      h = ($urandom & 32'hFFFF_FC00) | $urandom_range(0, 7);
      rh = ($urandom & 32'hFFFF_FC00) | $urandom_range(0, 7);
      x = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 1) == 1) x = rev(x);
      if ($urandom_range(0, 9) == 0) clear_idle(10'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
      else lookup(x, h, rh, $urandom_range(0, 5), $urandom_range(0, 9) == 0, 10'($urandom_range(0, 7)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
